// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle main control FSM and the MIPS datapath.
// master: the control FSM (takes instruction fields and MemReady, drives enables).
// slave:  the datapath side (drives instruction fields and MemReady, takes enables).
interface multicycle_main_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             MemReady;

    logic             PCWrite;
    logic             BranchEq;
    logic             BranchNe;
    logic             BranchGtz;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemToReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [2:0]       ALUOp;
    logic [3:0]       State;
    logic             IllegalOp;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        input  Opcode, Funct, MemReady,
        output PCWrite, BranchEq, BranchNe, BranchGtz, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, State, IllegalOp, RetireCount
    );

    modport slave (
        output Opcode, Funct, MemReady,
        input  PCWrite, BranchEq, BranchNe, BranchGtz, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALUOp, State, IllegalOp, RetireCount
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: lw 5, sw/R/I 4, branch/j 3 cycles plus one per MemReady=0 cycle in memory states.
// Backpressure: FETCH, MEMRD and MEMWR hold while MemReady is low (unless USE_MEM_READY=0).
// Ports: clk, rst_n (async active-low), bus (master modport: Opcode/Funct/MemReady in,
// all datapath enables, ALUOp, State, IllegalOp, RetireCount out).
module multicycle_main_control #(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_main_control_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_IDLE   = 4'hF
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           state_q, state_d;
    logic             retire_evt;
    logic             illegal_evt;
    logic             illegal_q;
    logic [CNT_W-1:0] retire_q;
    logic             mem_rdy;
    logic [2:0]       imm_aluop;

    assign mem_rdy = USE_MEM_READY ? bus.MemReady : 1'b1;

    // Immediate ALU class is shared by IEXEC and IWB so the result stays stable
    // through writeback.
    always_comb begin
        imm_aluop = 3'b000;
        case (bus.Opcode)
            OP_ANDI: imm_aluop = 3'b100;
            OP_ORI:  imm_aluop = 3'b101;
            OP_SLTI: imm_aluop = 3'b111;
            default: imm_aluop = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q <= state_d;
            if (illegal_evt)
                illegal_q <= 1'b1;
            if (retire_evt)
                retire_q <= retire_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        retire_evt    = 1'b0;
        illegal_evt   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.BranchEq  = 1'b0;
        bus.BranchNe  = 1'b0;
        bus.BranchGtz = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.PCSource  = 2'b00;
        bus.ALUOp     = 3'b000;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                // IR and PC+4 only commit on the cycle the fetch data is valid.
                bus.IRWrite = mem_rdy;
                bus.PCWrite = mem_rdy;
                if (mem_rdy)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_R:                              state_d = S_REXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ:           state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_evt = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (mem_rdy)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemToReg = 1'b1;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                retire_evt   = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (mem_rdy) begin
                    state_d    = S_FETCH;
                    retire_evt = 1'b1;
                end
            end
            S_REXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b010;
                state_d     = S_RWB;
            end
            S_RWB: begin
                bus.RegDst   = 1'b1;
                bus.ALUOp    = 3'b010;
                // Funct 000000 is the canonical NOP: retire without touching $zero's neighbours.
                bus.RegWrite = (bus.Funct != 6'b000000);
                state_d      = S_FETCH;
                retire_evt   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.PCSource = 2'b01;
                case (bus.Opcode)
                    OP_BEQ:  begin bus.ALUOp = 3'b001; bus.BranchEq  = 1'b1; end
                    OP_BNE:  begin bus.ALUOp = 3'b001; bus.BranchNe  = 1'b1; end
                    OP_BGTZ: begin bus.ALUOp = 3'b110; bus.BranchGtz = 1'b1; end
                    default: bus.ALUOp = 3'b000;
                endcase
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = imm_aluop;
                state_d     = S_IWB;
            end
            S_IWB: begin
                bus.ALUOp    = imm_aluop;
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
                retire_evt   = 1'b1;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_d      = S_FETCH;
                retire_evt   = 1'b1;
            end
            // Encodings 12-14 are unreachable; recover to FETCH with everything off.
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.State       = state_q;
    assign bus.IllegalOp   = illegal_q;
    assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_main_control_if #(.CNT_W(16)) bus ();
    multicycle_main_control_if #(.CNT_W(2))  bus2 ();

    multicycle_main_control #(.USE_MEM_READY(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
    multicycle_main_control #(.USE_MEM_READY(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2.master)
    );

    typedef struct packed {
        logic       pcw, beq, bne, bgtz, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aop;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        int         ret;
        logic       ill;
    } ent_t;

    ent_t  sb[$];
    ctrl_t got_c;
    int    exp_ret = 0;
    logic  exp_ill = 1'b0;

    assign got_c = {bus.PCWrite, bus.BranchEq, bus.BranchNe, bus.BranchGtz, bus.IorD,
                    bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemToReg,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected Moore outputs per state, straight from the control table.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            4'd1:  c.srcb = 2'b11;
            4'd2:  begin c.srca = 1; c.srcb = 2'b10; end
            4'd3:  begin c.mrd = 1; c.iord = 1; end
            4'd4:  begin c.m2r = 1; c.rw = 1; end
            4'd5:  begin c.mwr = 1; c.iord = 1; end
            4'd6:  begin c.srca = 1; c.aop = 3'b010; end
            4'd7:  begin c.rdst = 1; c.rw = (fn != 6'd0); c.aop = 3'b010; end
            4'd8: begin
                c.srca = 1; c.pcsrc = 2'b01;
                if (op == 6'b000100) begin c.aop = 3'b001; c.beq = 1; end
                if (op == 6'b000101) begin c.aop = 3'b001; c.bne = 1; end
                if (op == 6'b000111) begin c.aop = 3'b110; c.bgtz = 1; end
            end
            4'd9, 4'd10: begin
                if (st == 4'd9) begin c.srca = 1; c.srcb = 2'b10; end
                else c.rw = 1;
                if (op == 6'b001100) c.aop = 3'b100;
                if (op == 6'b001101) c.aop = 3'b101;
                if (op == 6'b001010) c.aop = 3'b111;
            end
            4'd11: begin c.pcw = 1; c.pcsrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr);
        ent_t e;
        e.st = st; e.op = op; e.fn = fn; e.mr = mr; e.ret = exp_ret; e.ill = exp_ill;
        sb.push_back(e);
    endtask

    // Queue the expected per-cycle trace of one instruction.
    // fw = FETCH wait cycles, mw = MEMRD/MEMWR wait cycles.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        logic legal;
        legal = 1'b1;
        repeat (fw) push(4'd0, op, fn, 1'b0);
        push(4'd0, op, fn, 1'b1);
        push(4'd1, op, fn, 1'($urandom_range(0, 1)));
        case (op)
            6'b100011: begin
                push(4'd2, op, fn, 1'b0);
                repeat (mw) push(4'd3, op, fn, 1'b0);
                push(4'd3, op, fn, 1'b1);
                push(4'd4, op, fn, 1'($urandom_range(0, 1)));
            end
            6'b101011: begin
                push(4'd2, op, fn, 1'b0);
                repeat (mw) push(4'd5, op, fn, 1'b0);
                push(4'd5, op, fn, 1'b1);
            end
            6'b000000: begin
                push(4'd6, op, fn, 1'($urandom_range(0, 1)));
                push(4'd7, op, fn, 1'($urandom_range(0, 1)));
            end
            6'b000100, 6'b000101, 6'b000111: push(4'd8, op, fn, 1'($urandom_range(0, 1)));
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                push(4'd9, op, fn, 1'($urandom_range(0, 1)));
                push(4'd10, op, fn, 1'($urandom_range(0, 1)));
            end
            6'b000010: push(4'd11, op, fn, 1'($urandom_range(0, 1)));
            default: legal = 1'b0;
        endcase
        if (legal) exp_ret++;
        else exp_ill = 1'b1;
    endtask

    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            bus.Opcode = e.op;
            bus.Funct = e.fn;
            bus.MemReady = e.mr;
            @(negedge clk);
            check($sformatf("state(exp %0d)", e.st), 32'(bus.State), 32'(e.st));
            check($sformatf("ctrl(st %0d)", e.st), 32'(got_c), 32'(exp_ctrl(e.st, e.op, e.fn, e.mr)));
            check($sformatf("retire(st %0d)", e.st), 32'(bus.RetireCount), 32'(e.ret));
            check($sformatf("illegal(st %0d)", e.st), 32'(bus.IllegalOp), 32'(e.ill));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(bus.State), 32'hF);
        check({tag, "_ctrl"}, 32'(got_c), 32'h0);
        check({tag, "_retire"}, 32'(bus.RetireCount), 32'h0);
        check({tag, "_illegal"}, 32'(bus.IllegalOp), 32'h0);
    endtask

    initial begin
        bus.Opcode = 6'd0; bus.Funct = 6'd0; bus.MemReady = 1'b0;
        bus2.Opcode = 6'b000010; bus2.Funct = 6'd0; bus2.MemReady = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("in_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(bus.State), 32'hF);

        issue(6'b100011, 6'd0, 0, 2);        // lw, 2 MEMRD waits -> 7 cycles
        issue(6'b000000, 6'b100000, 0, 0);   // R-type add
        issue(6'b000000, 6'b000000, 0, 0);   // NOP
        issue(6'b000111, 6'd0, 0, 0);        // bgtz
        issue(6'b000100, 6'd0, 0, 0);        // beq
        issue(6'b001101, 6'd0, 1, 0);        // ori with one FETCH wait
        issue(6'b111111, 6'd0, 0, 0);        // illegal
        issue(6'b000010, 6'd0, 0, 0);        // j, IllegalOp stays set
        issue(6'b101011, 6'd0, 0, 1);        // sw, one MEMWR wait
        drain();

        // sw stalled in MEMWR, then async reset mid-cycle
        push(4'd0, 6'b101011, 6'd0, 1'b1);
        push(4'd1, 6'b101011, 6'd0, 1'b0);
        push(4'd2, 6'b101011, 6'd0, 1'b0);
        push(4'd5, 6'b101011, 6'd0, 1'b0);
        drain();
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        exp_ret = 0; exp_ill = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rerelease", 32'(bus.State), 32'hF);

        issue(6'b001000, 6'd0, 0, 0);        // addi
        issue(6'b001100, 6'd0, 0, 0);        // andi
        issue(6'b001010, 6'd0, 2, 0);        // slti, two FETCH waits
        issue(6'b000101, 6'd0, 0, 0);        // bne
        issue(6'b100011, 6'd0, 0, 0);        // lw, no waits
        drain();

        // Second instance: CNT_W=2, MemReady ignored; 5 jumps wrap the counter to 1.
        @(posedge clk); #1 rst2_n = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("wrap_state", 32'(bus2.State), 32'h0);
        check("wrap_retire", 32'(bus2.RetireCount), 32'h1);
        check("nostall_irwrite", 32'(bus2.IRWrite), 32'h1);
        check("nostall_pcwrite", 32'(bus2.PCWrite), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
